fetch_stage: RTL and testbench

Instruction fetch stage of the pipeline and the producer end of the DR interface that the decode stage consumes.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Registers the returned word into DR, with its PC+4 in NPC and a valid flag.
- Obeys stall from the hazard logic and redirect (branch/jump target) from later stages, discarding wrong-path words.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_pc_reg.sv | 28 ++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and the decode stage that consumes DR.
package fetch_stage_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DROP  = 2'd2
   } fetch_state_t;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return addr & {{(WORD_W-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, hazard/redirect controls and the DR output.
interface fetch_stage_if
   import fetch_stage_pkg::*;
   ();

   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_data;
   logic              stall;
   logic              redirect;
   logic [WORD_W-1:0] redirect_pc;
   logic [WORD_W-1:0] DR;
   logic [WORD_W-1:0] NPC;
   logic              dr_valid;

   modport master (
      output imem_req, imem_addr, DR, NPC, dr_valid,
      input  imem_ack, imem_data, stall, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, DR, NPC, dr_valid,
      output imem_ack, imem_data, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: word-aligned redirect load, +4 increment (modulo 2^32), async reset.
module fetch_pc_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              load,
   input  logic [WORD_W-1:0] load_pc,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc_plus4
);

   assign pc_plus4 = pc + 32'd4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= word_align(load_pc);
      end else if (inc) begin
         pc <= pc_plus4;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem req/ack handshake, DR/NPC registers with stall and redirect.
//
// state    | meaning
// ST_FETCH | request to imem outstanding (or about to be issued after reset)
// ST_HOLD  | fetched word parked in hold buffer while decode stalls
// ST_DROP  | wrong-path request outstanding; its data is discarded on ack
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   fetch_state_t      state, state_nxt;
   logic              req, req_nxt;
   logic [WORD_W-1:0] addr, addr_nxt;
   logic [WORD_W-1:0] dr, dr_nxt;
   logic [WORD_W-1:0] npc, npc_nxt;
   logic              valid, valid_nxt;
   logic [WORD_W-1:0] hold, hold_nxt;
   logic              pc_inc, pc_load;
   logic [WORD_W-1:0] pc, pc_plus4, target;
   logic              ack;

   fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk      (clk),
      .reset    (reset),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_pc  (bus.redirect_pc),
      .pc       (pc),
      .pc_plus4 (pc_plus4)
   );

   assign target = word_align(bus.redirect_pc);
   // an ack with no request outstanding is spurious and ignored
   assign ack    = bus.imem_ack & req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_FETCH;
         req   <= 1'b0;
         addr  <= RESET_PC;
         dr    <= NOP_INSTR;
         npc   <= '0;
         valid <= 1'b0;
         hold  <= NOP_INSTR;
      end else begin
         state <= state_nxt;
         req   <= req_nxt;
         addr  <= addr_nxt;
         dr    <= dr_nxt;
         npc   <= npc_nxt;
         valid <= valid_nxt;
         hold  <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = req;
      addr_nxt  = addr;
      dr_nxt    = dr;
      npc_nxt   = npc;
      valid_nxt = valid;
      hold_nxt  = hold;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;

      if (bus.redirect) begin
         dr_nxt    = NOP_INSTR;
         valid_nxt = 1'b0;
         pc_load   = 1'b1;
      end

      case (state)
         ST_FETCH: begin
            if (bus.redirect) begin
               if (!req || ack) begin
                  req_nxt  = 1'b1;
                  addr_nxt = target;
               end else begin
                  state_nxt = ST_DROP;
               end
            end else if (!req) begin
               req_nxt  = 1'b1;
               addr_nxt = pc;
            end else if (ack && !bus.stall) begin
               dr_nxt    = bus.imem_data;
               npc_nxt   = pc_plus4;
               valid_nxt = 1'b1;
               pc_inc    = 1'b1;
               addr_nxt  = pc_plus4;
            end else if (ack) begin
               hold_nxt  = bus.imem_data;
               pc_inc    = 1'b1;
               addr_nxt  = pc_plus4;
               req_nxt   = 1'b0;
               state_nxt = ST_HOLD;
            end else if (!bus.stall) begin
               dr_nxt    = NOP_INSTR;
               valid_nxt = 1'b0;
            end
         end
         ST_HOLD: begin
            if (bus.redirect) begin
               hold_nxt  = NOP_INSTR;
               req_nxt   = 1'b1;
               addr_nxt  = target;
               state_nxt = ST_FETCH;
            end else if (!bus.stall) begin
               dr_nxt    = hold;
               npc_nxt   = pc;
               valid_nxt = 1'b1;
               req_nxt   = 1'b1;
               addr_nxt  = pc;
               state_nxt = ST_FETCH;
            end
         end
         ST_DROP: begin
            // the old request completes; restart at the newest target
            if (ack) begin
               req_nxt   = 1'b1;
               addr_nxt  = bus.redirect ? target : pc;
               state_nxt = ST_FETCH;
            end
         end
         default: begin
            state_nxt = ST_FETCH;
         end
      endcase
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = addr;
   assign bus.DR        = dr;
   assign bus.NPC       = npc;
   assign bus.dr_valid  = valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; memory returns addr ^ 32'h1357_9BDF.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic auto_ack = 1'b1;
   logic man_ack = 1'b0;
   int   checks = 0;
   int   failures = 0;

   fetch_stage_if bus();

   fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign bus.imem_ack  = auto_ack ? bus.imem_req : man_ack;
   assign bus.imem_data = mem_word(bus.imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      auto_ack = 1'b1;
      man_ack = 1'b0;
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      step();
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.DR, bus.NPC, bus.dr_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got req=%b addr=%h DR=%h NPC=%h v=%b", bus.imem_req, bus.imem_addr, bus.DR, bus.NPC, bus.dr_valid);
      end
   endtask

   task automatic test_zero_wait();
      do_reset();
      step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.dr_valid !== 1'b0) begin
         failures++;
         $display("FAIL zw_first_req got req=%b addr=%h v=%b exp req=1 addr=0 v=0", bus.imem_req, bus.imem_addr, bus.dr_valid);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (bus.imem_addr !== 32'(4*i) || bus.DR !== mem_word(32'(4*(i-1))) ||
             bus.NPC !== 32'(4*i) || bus.dr_valid !== 1'b1) begin
            failures++;
            $display("FAIL zw_stream[%0d] got addr=%h DR=%h NPC=%h v=%b exp addr=%h DR=%h NPC=%h v=1",
                     i, bus.imem_addr, bus.DR, bus.NPC, bus.dr_valid, 32'(4*i), mem_word(32'(4*(i-1))), 32'(4*i));
         end
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      auto_ack = 1'b0;
      man_ack = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         for (int w = 0; w < 2; w++) begin
            man_ack = 1'b0;
            step();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*k) || bus.dr_valid !== 1'b0 || bus.DR !== 32'h0) begin
               failures++;
               $display("FAIL wait_bubble[%0d.%0d] got req=%b addr=%h v=%b DR=%h exp req=1 addr=%h v=0 DR=0",
                        k, w, bus.imem_req, bus.imem_addr, bus.dr_valid, bus.DR, 32'(4*k));
            end
         end
         man_ack = 1'b1;
         step();
         man_ack = 1'b0;
         checks++;
         if (bus.DR !== mem_word(32'(4*k)) || bus.NPC !== 32'(4*k+4) || bus.dr_valid !== 1'b1 || bus.imem_addr !== 32'(4*k+4)) begin
            failures++;
            $display("FAIL wait_data[%0d] got DR=%h NPC=%h v=%b addr=%h exp DR=%h NPC=%h v=1 addr=%h",
                     k, bus.DR, bus.NPC, bus.dr_valid, bus.imem_addr, mem_word(32'(4*k)), 32'(4*k+4), 32'(4*k+4));
         end
      end
   endtask

   task automatic test_stall_hold();
      do_reset();
      for (int e = 0; e < 5; e++) step();
      checks++;
      if (bus.imem_addr !== 32'h10) begin
         failures++;
         $display("FAIL stall_pre_addr got %h exp 00000010", bus.imem_addr);
      end
      bus.stall = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step();
         checks++;
         if (bus.imem_req !== 1'b0 || bus.DR !== mem_word(32'hC) || bus.NPC !== 32'h10 || bus.dr_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_frozen[%0d] got req=%b DR=%h NPC=%h v=%b exp req=0 DR=%h NPC=10 v=1",
                     j, bus.imem_req, bus.DR, bus.NPC, bus.dr_valid, mem_word(32'hC));
         end
      end
      bus.stall = 1'b0;
      step();
      checks++;
      if (bus.DR !== mem_word(32'h10) || bus.NPC !== 32'h14 || bus.dr_valid !== 1'b1 ||
          bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
         failures++;
         $display("FAIL stall_release got DR=%h NPC=%h v=%b req=%b addr=%h exp DR=%h NPC=14 v=1 req=1 addr=14",
                  bus.DR, bus.NPC, bus.dr_valid, bus.imem_req, bus.imem_addr, mem_word(32'h10));
      end
   endtask

   task automatic test_redirect_pending();
      do_reset();
      for (int e = 0; e < 9; e++) step();
      auto_ack = 1'b0;
      man_ack = 1'b0;
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_0103;
      step();
      bus.redirect = 1'b0;
      for (int j = 0; j < 2; j++) begin
         checks++;
         if (bus.dr_valid !== 1'b0 || bus.DR !== 32'h0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin
            failures++;
            $display("FAIL redir_drop[%0d] got v=%b DR=%h req=%b addr=%h exp v=0 DR=0 req=1 addr=20",
                     j, bus.dr_valid, bus.DR, bus.imem_req, bus.imem_addr);
         end
         if (j == 1) man_ack = 1'b1;
         step();
      end
      checks++;
      if (bus.imem_addr !== 32'h100 || bus.dr_valid !== 1'b0 || bus.NPC !== 32'h20) begin
         failures++;
         $display("FAIL redir_discard got addr=%h v=%b NPC=%h exp addr=100 v=0 NPC=20", bus.imem_addr, bus.dr_valid, bus.NPC);
      end
      step();
      man_ack = 1'b0;
      checks++;
      if (bus.DR !== mem_word(32'h100) || bus.NPC !== 32'h104 || bus.dr_valid !== 1'b1) begin
         failures++;
         $display("FAIL redir_target got DR=%h NPC=%h v=%b exp DR=%h NPC=104 v=1", bus.DR, bus.NPC, bus.dr_valid, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_hold();
      do_reset();
      step();
      bus.stall = 1'b1;
      step();
      checks++;
      if (bus.imem_req !== 1'b0) begin
         failures++;
         $display("FAIL rh_in_hold got req=%b exp 0", bus.imem_req);
      end
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'h0000_0200;
      step();
      checks++;
      if (bus.DR !== 32'h0 || bus.dr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
         failures++;
         $display("FAIL rh_flush got DR=%h v=%b req=%b addr=%h exp DR=0 v=0 req=1 addr=200",
                  bus.DR, bus.dr_valid, bus.imem_req, bus.imem_addr);
      end
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      step();
      checks++;
      if (bus.DR !== mem_word(32'h200) || bus.NPC !== 32'h204 || bus.dr_valid !== 1'b1) begin
         failures++;
         $display("FAIL rh_resume got DR=%h NPC=%h v=%b exp DR=%h NPC=204 v=1", bus.DR, bus.NPC, bus.dr_valid, mem_word(32'h200));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step();
      bus.redirect = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      checks++;
      if (bus.imem_addr !== 32'hFFFF_FFFC || bus.imem_req !== 1'b1 || bus.dr_valid !== 1'b0) begin
         failures++;
         $display("FAIL wrap_issue got addr=%h req=%b v=%b exp addr=fffffffc req=1 v=0", bus.imem_addr, bus.imem_req, bus.dr_valid);
      end
      step();
      checks++;
      if (bus.DR !== mem_word(32'hFFFF_FFFC) || bus.NPC !== 32'h0 || bus.imem_addr !== 32'h0 || bus.dr_valid !== 1'b1) begin
         failures++;
         $display("FAIL wrap_npc got DR=%h NPC=%h addr=%h v=%b exp DR=%h NPC=0 addr=0 v=1",
                  bus.DR, bus.NPC, bus.imem_addr, bus.dr_valid, mem_word(32'hFFFF_FFFC));
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step();
      step();
      auto_ack = 1'b0;
      man_ack = 1'b0;
      step();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.NPC !== 32'h4 || bus.dr_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmid_pending got req=%b addr=%h NPC=%h v=%b exp req=1 addr=4 NPC=4 v=0",
                  bus.imem_req, bus.imem_addr, bus.NPC, bus.dr_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.imem_req, bus.imem_addr, bus.DR, bus.NPC, bus.dr_valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL rmid_async got req=%b addr=%h DR=%h NPC=%h v=%b exp all zero",
                  bus.imem_req, bus.imem_addr, bus.DR, bus.NPC, bus.dr_valid);
      end
      step();
      checks++;
      if (bus.imem_req !== 1'b0) begin
         failures++;
         $display("FAIL rmid_held got req=%b exp 0", bus.imem_req);
      end
      reset = 1'b0;
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_hold();
      test_redirect_pending();
      test_redirect_hold();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
